// File: rtl/led_fader_pkg.sv
// Shared constants and gamma table for the eight-channel LED fader.
// The gamma table is used only when LED_FADER_GAMMA_EN is defined.
package led_fader_pkg;

  localparam int LED_COUNT = 8;
  localparam int LEVEL_W   = 4;

  typedef logic [LEVEL_W-1:0] level_t;

  localparam level_t LEVEL_MAX = level_t'(15);

  // Perceptual brightness curve, indexed by linear level 0..15.
  localparam level_t GAMMA [16] = '{
    4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2,  4'd2,
    4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15
  };

  function automatic level_t gamma_lookup(input level_t lvl);
    return GAMMA[lvl];
  endfunction

endpackage

// File: rtl/led_fader_if.sv
// Pattern input, enable and LED drive outputs of the fader.
// master drives en/pattern_in, slave (the fader) drives led_out/all_dark.
interface led_fader_if;
  import led_fader_pkg::*;

  logic                 en;
  logic [LED_COUNT-1:0] pattern_in;
  logic [LED_COUNT-1:0] led_out;
  logic                 all_dark;

  modport master (
    output en,
    output pattern_in,
    input  led_out,
    input  all_dark
  );

  modport slave (
    input  en,
    input  pattern_in,
    output led_out,
    output all_dark
  );

endinterface

// File: rtl/led_fader_channel.sv
// One LED channel: brightness level with set/decay, duty map and PWM output flop.
// Duty mapping is gamma-corrected when LED_FADER_GAMMA_EN is defined, linear otherwise.
module led_fader_channel
  import led_fader_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  input  logic   i_set,
  input  logic   i_step_tick,
  input  level_t i_pwm_cnt,
  output level_t o_level,
  output logic   o_led
);

  level_t r_level;
  level_t w_level_nxt;
  level_t w_duty;
  logic   r_led;

  // Set beats decay when both happen on the same cycle.
  always_comb begin
    w_level_nxt = r_level;
    if (i_en) begin
      if (i_set) begin
        w_level_nxt = LEVEL_MAX;
      end else if (i_step_tick && (r_level != '0)) begin
        w_level_nxt = r_level - level_t'(1);
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  assign w_duty = gamma_lookup(w_level_nxt);
`else
  assign w_duty = w_level_nxt;
`endif

  // Output follows the level being written on this same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_led   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_led   <= i_en & ((w_duty == LEVEL_MAX) | (i_pwm_cnt < w_duty));
    end
  end

  assign o_level = r_level;
  assign o_led   = r_led;

endmodule

// File: rtl/led_fader.sv
// Eight-channel LED fader: lit pattern bits jump to full brightness, then decay one
// level per step tick. Optional gamma mapping is enabled by LED_FADER_GAMMA_EN.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int STEP_HZ  = 64
) (
  input  logic         clk,
  input  logic         rst,
  led_fader_if.slave   bus
);

  localparam int STEP_DIV = CLK_FREQ / STEP_HZ;
  localparam int PRESC_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

  if (STEP_DIV < 2) begin : g_bad_div
    $error("led_fader: CLK_FREQ/STEP_HZ must be at least 2");
  end

  logic [LED_COUNT-1:0] r_pattern_q;
  logic [PRESC_W-1:0]   r_presc;
  level_t               r_pwm_cnt;
  logic                 r_all_dark;
  logic                 w_step_tick;
  logic                 w_levels_zero;
  level_t               w_level [LED_COUNT];
  logic [LED_COUNT-1:0] w_led;

  assign w_step_tick = bus.en & (r_presc == PRESC_LAST);

  // The pattern stage keeps sampling even while the fader is paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern_q <= '0;
    end else begin
      r_pattern_q <= bus.pattern_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
    end else if (bus.en) begin
      r_presc   <= (r_presc == PRESC_LAST) ? '0 : r_presc + PRESC_W'(1);
      r_pwm_cnt <= r_pwm_cnt + level_t'(1);
    end
  end

  for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_ch
    led_fader_channel u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_en        (bus.en),
      .i_set       (r_pattern_q[gi]),
      .i_step_tick (w_step_tick),
      .i_pwm_cnt   (r_pwm_cnt),
      .o_level     (w_level[gi]),
      .o_led       (w_led[gi])
    );
  end

  always_comb begin
    w_levels_zero = 1'b1;
    for (int i = 0; i < LED_COUNT; i++) begin
      if (w_level[i] != '0) begin
        w_levels_zero = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_all_dark <= 1'b1;
    end else begin
      r_all_dark <= w_levels_zero;
    end
  end

  assign bus.led_out  = w_led;
  assign bus.all_dark = r_all_dark;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with CLK_FREQ=1600, STEP_HZ=100 (16-cycle fade step).
// Expected PWM counts follow LED_FADER_GAMMA_EN when the bench is built with it.
module tb_led_fader;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   n = 0;
  logic adv;
  logic [7:0] pq_exp = 8'h00;
  logic [7:0] pq_before;
  int   exp_lvl;
  int   exp3;
  int   cnt;
  int   guard;

  led_fader_if bus ();

  led_fader #(.CLK_FREQ(1600), .STEP_HZ(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // n counts enabled edges since reset release; a decay edge is n%16==0.
  task automatic step();
    pq_before = pq_exp;
    adv = bus.en && !rst;
    @(posedge clk);
    pq_exp = rst ? 8'h00 : bus.pattern_in;
    if (rst) n = 0;
    else if (adv) n++;
    #1;
  endtask

  function automatic int exp_highs(input int lvl);
    int duty;
`ifdef LED_FADER_GAMMA_EN
    int gtab [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
    duty = gtab[lvl];
`else
    duty = lvl;
`endif
    return (duty == 15) ? 16 : duty;
  endfunction

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.pattern_in = 8'h00;
    repeat (3) step();
    check_val("rst_led", int'(bus.led_out), 0);
    check_val("rst_dark", int'(bus.all_dark), 1);
    check_val("rst_lvl0", int'(dut.g_ch[0].u_ch.r_level), 0);

    rst = 1'b0;
    bus.en = 1'b1;
    step();
    check_val("presc_start", int'(dut.r_presc), 1);
    for (int i = 0; i < 19; i++) begin
      step();
      check_val("idle", int'({bus.led_out, bus.all_dark}), 1);
    end

    // Latency: pattern driven now, pattern_q next edge, level+led the edge after.
    bus.pattern_in = 8'h01;
    step();
    check_val("lat1_led", int'(bus.led_out), 0);
    step();
    check_val("lat2_led", int'(bus.led_out), 1);
    check_val("lat2_dark", int'(bus.all_dark), 1);
    step();
    check_val("lat3_dark", int'(bus.all_dark), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("hold_high", int'(bus.led_out), 1);
    end
    check_val("hold_lvl", int'(dut.g_ch[0].u_ch.r_level), 15);

    // Fade channel 0 to zero, measuring PWM highs for a full window per level.
    bus.pattern_in = 8'h00;
    exp_lvl = 15;
    cnt = 0;
    guard = 0;
    while (exp_lvl != 0 && guard < 400) begin
      step();
      guard++;
      if (adv && (n % 16 == 0) && !pq_before[0]) begin
        if (exp_lvl == 12 || exp_lvl == 8 || exp_lvl == 2)
          check_val($sformatf("pwm_l%0d", exp_lvl), cnt, exp_highs(exp_lvl));
        exp_lvl--;
        cnt = 0;
        check_val("fade_lvl", int'(dut.g_ch[0].u_ch.r_level), exp_lvl);
      end
      cnt += int'(bus.led_out[0]);
    end
    check_val("fade_done_lvl", int'(dut.g_ch[0].u_ch.r_level), 0);
    check_val("dark_lag0", int'(bus.all_dark), 0);
    step();
    check_val("dark_after", int'(bus.all_dark), 1);

    // Channel 3: set and decay coincide; set must win.
    bus.pattern_in = 8'h08;
    step();
    step();
    bus.pattern_in = 8'h00;
    guard = 0;
    exp3 = 15;
    while (exp3 == 15 && guard < 40) begin
      step();
      guard++;
      if (adv && (n % 16 == 0) && !pq_before[3]) exp3--;
    end
    check_val("ch3_first_decay", int'(dut.g_ch[3].u_ch.r_level), 14);
    while ((n % 16) != 14) step();
    bus.pattern_in = 8'h08;
    step();
    bus.pattern_in = 8'h00;
    step();
    check_val("set_wins_n", n % 16, 0);
    check_val("set_wins_lvl", int'(dut.g_ch[3].u_ch.r_level), 15);
    check_val("set_wins_led", int'(bus.led_out), 8'h08);

    // Decay channel 3 to 9, then pause mid-interval.
    exp3 = 15;
    guard = 0;
    while (exp3 != 9 && guard < 200) begin
      step();
      guard++;
      if (adv && (n % 16 == 0) && !pq_before[3]) exp3--;
    end
    check_val("gate_pre_lvl", int'(dut.g_ch[3].u_ch.r_level), 9);
    repeat (5) step();
    bus.en = 1'b0;
    step();
    check_val("gate_led", int'(bus.led_out), 0);
    repeat (30) step();
    check_val("gate_led_held", int'(bus.led_out), 0);
    check_val("gate_lvl_held", int'(dut.g_ch[3].u_ch.r_level), 9);
    check_val("gate_presc", int'(dut.r_presc), 5);
    bus.en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (adv && (n % 16 == 0) && !pq_before[3]) exp3--;
      check_val("resume_lvl", int'(dut.g_ch[3].u_ch.r_level), exp3);
    end
    check_val("resume_final", int'(dut.g_ch[3].u_ch.r_level), 8);

    // Reset mid-fade overrides enable and pattern.
    bus.pattern_in = 8'h20;
    rst = 1'b1;
    step();
    check_val("midrst_led", int'(bus.led_out), 0);
    check_val("midrst_dark", int'(bus.all_dark), 1);
    check_val("midrst_lvl3", int'(dut.g_ch[3].u_ch.r_level), 0);
    check_val("midrst_pq", int'(dut.r_pattern_q), 0);
    bus.pattern_in = 8'h00;
    rst = 1'b0;
    step();
    check_val("restart_presc", int'(dut.r_presc), 1);
    check_val("restart_pwm", int'(dut.r_pwm_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter STEP_HZ, default 64, fade-step rate in Hz; STEP_DIV = CLK_FREQ/STEP_HZ SHALL be >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  run enable.
REQ-006 SHALL have port pattern_in  input  8  LED pattern from the upstream shifter stage; bit i high = LED i lit.
REQ-007 SHALL have port led_out  output  8  PWM-modulated LED drive, registered.
REQ-008 SHALL have port all_dark  output  1  high when every channel level is 0, registered.

Function
REQ-009 SHALL register pattern_in into pattern_q every cycle, regardless of en.
REQ-010 SHALL keep one 4-bit brightness level per LED, range 0..15.
REQ-011 SHALL run a step prescaler counting 0..STEP_DIV-1 while en=1; step_tick = 1 on the cycle the count equals STEP_DIV-1, and the count then wraps to 0.
REQ-012 SHALL, when en=1 and pattern_q[i]=1, load level[i] to 15 on the next edge, regardless of step_tick.
REQ-013 SHALL, when en=1, pattern_q[i]=0 and step_tick=1, decrement level[i] by 1 and saturate at 0.
REQ-014 SHALL, on simultaneous pattern_q[i]=1 and step_tick, apply the set (15) and not the decay.
REQ-015 SHALL run a free-running 4-bit pwm_cnt (period 16 clocks) that increments while en=1 and wraps 15->0.
REQ-016 SHALL compute duty[i] = level[i] without gamma (see REQ-024); led_out[i] <= (duty[i]==15) | (pwm_cnt < duty[i]).
REQ-017 SHALL give a latency of 2 edges from pattern_in[i] rising to led_out[i]=1 (1 edge into pattern_q, 1 edge into level, same edge updates led_out from the new level).
REQ-018 SHALL, when en=0, freeze the prescaler, pwm_cnt and all levels, and drive led_out to 0 on the next edge.
REQ-019 SHALL register all_dark <= (all levels == 0) and update it independently of en.

Reset
REQ-020 SHALL, on rst=1 at a clock edge, clear pattern_q, all levels, the prescaler and pwm_cnt to 0, and drive led_out=0 and all_dark=1.
REQ-021 SHALL give rst priority over en and pattern_in, including mid-fade.
REQ-022 SHALL start a fresh STEP_DIV interval from count 0 on the first cycle after rst is released.

Configuration
REQ-023 SHALL compile the gamma mapping only when the macro LED_FADER_GAMMA_EN is defined.
REQ-024 SHALL, with LED_FADER_GAMMA_EN defined, set duty[i] = GAMMA[level[i]] with GAMMA = {0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15}; without the macro, duty[i] = level[i].
REQ-025 SHALL leave ports, latency and reset behaviour identical in both builds.

Structure
REQ-026 SHALL place LED_COUNT=8, LEVEL_W=4, LEVEL_MAX=15 and the GAMMA table in the shared package led_fader_pkg.
REQ-027 SHALL instantiate one sub-module per LED, led_fader_channel (level register, set/decay logic, duty map, comparator, output flop); the top level holds pattern_q, the prescaler, pwm_cnt and all_dark.

Verification (CLK_FREQ=1600, STEP_HZ=100, so STEP_DIV=16)
REQ-028 SHALL cover: rst high for 3 cycles, then released with en=1 and pattern_in=0 -> led_out=0 and all_dark=1 throughout.
REQ-029 SHALL cover: pattern_in=8'h01 applied at edge N -> led_out[0]=1 from edge N+2, constant high; all_dark=0 one edge after level[0] becomes 15.
REQ-030 SHALL cover: pattern_in 8'h01 then 8'h00 -> level[0] steps 15,14,...,0, one step per 16 cycles; after 15 ticks all_dark=1; no gamma: level 8 gives 8 high in 16 PWM clocks.
REQ-031 SHALL cover: pattern_q[3]=1 on a step_tick cycle -> level[3]=15, no decrement.
REQ-032 SHALL cover: en=0 mid-fade at level 9 -> led_out=0 next edge, level held at 9; en=1 -> decay resumes from 9 with prescaler continuing from its frozen count.
REQ-033 SHALL cover: LED_FADER_GAMMA_EN build at level 12 -> 8 high per 16 PWM clocks; at level 2 -> led_out stays 0.
